// File: rtl/rifl_tx_crc_gen.sv
// rifl_tx_crc_gen: TX frame protector, CRC over payload XOR per-frame sequence number, registered valid/ready output.
// Optional error injection on m_crc bit 0 is enabled by defining RIFL_TX_CRC_ERR_INJ_EN.
module rifl_tx_crc_gen #(
  parameter int                PAYLOAD_W = 116,
  parameter int                CRC_W     = 8,
  parameter logic [CRC_W-1:0]  CRC_POLY  = 8'hA7,
  parameter logic [CRC_W-1:0]  CRC_INIT  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef RIFL_TX_CRC_ERR_INJ_EN
  input  logic                 err_inj,
`endif
  input  logic [PAYLOAD_W-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 seq_load,
  input  logic [CRC_W-1:0]     seq_load_val,
  output logic [PAYLOAD_W-1:0] m_data,
  output logic [CRC_W-1:0]     m_crc,
  output logic [CRC_W-1:0]     m_seq,
  output logic                 m_valid,
  input  logic                 m_ready
);

  logic [CRC_W-1:0] seq_cnt;
  logic [CRC_W-1:0] crc_next;
  logic [CRC_W-1:0] err_mask;
  logic             accept;

  // Bit-serial MSB-first LFSR unrolled over the whole payload; synthesis flattens it to an XOR matrix.
  function automatic logic [CRC_W-1:0] crc_calc(input logic [PAYLOAD_W-1:0] data,
                                               input logic [CRC_W-1:0]     seed);
    logic [CRC_W-1:0] crc;
    logic             fb;
    crc = seed;
    for (int i = PAYLOAD_W - 1; i >= 0; i--) begin
      fb  = crc[CRC_W-1] ^ data[i];
      crc = {crc[CRC_W-2:0], 1'b0};
      if (fb) crc = crc ^ CRC_POLY;
    end
    return crc;
  endfunction

  assign s_ready  = !m_valid || m_ready;
  assign accept   = s_valid && s_ready;
  assign crc_next = crc_calc(s_data, CRC_INIT);

`ifdef RIFL_TX_CRC_ERR_INJ_EN
  assign err_mask = {{(CRC_W-1){1'b0}}, err_inj};
`else
  assign err_mask = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_crc   <= '0;
      m_seq   <= '0;
    end else if (accept) begin
      m_valid <= 1'b1;
      m_data  <= s_data;
      m_crc   <= crc_next ^ seq_cnt ^ err_mask;
      m_seq   <= seq_cnt;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

  // A reload wins over the increment; the frame accepted in the same cycle already captured the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_cnt <= '0;
    end else if (seq_load) begin
      seq_cnt <= seq_load_val;
    end else if (accept) begin
      seq_cnt <= seq_cnt + 1'b1;
    end
  end

endmodule
